// File: rtl/insn_decode_stage.sv
// Instruction decode stage: classifies raw opcodes, queues decoded ops in a small FIFO and
// fences issue after system-register writes and control transfers until they resolve.

module insn_decode_stage #(
    parameter int unsigned PC_W          = 32,
    parameter int unsigned DEPTH         = 4,
    parameter bit          SERIALIZE_MTS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_insn,
    input  logic [PC_W-1:0]          in_pc,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [2:0]               out_class,
    output logic [4:0]               out_rd,
    output logic [9:0]               out_sysreg,

    input  logic                     sysreg_wr_done,
    input  logic                     redirect,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = PC_W + 3 + 5 + 10;

    localparam logic [1:0] StRun       = 2'd0;
    localparam logic [1:0] StWaitWr    = 2'd1;
    localparam logic [1:0] StWaitRedir = 2'd2;

    localparam logic [2:0] ClsNop  = 3'd0;
    localparam logic [2:0] ClsMts  = 3'd1;
    localparam logic [2:0] ClsMfs  = 3'd2;
    localparam logic [2:0] ClsRet  = 3'd3;
    localparam logic [2:0] ClsJsrr = 3'd4;
    localparam logic [2:0] ClsIll  = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic             sys_space;
    logic             br_space;
    logic [2:0]       dec_class;
    logic             accept;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Combinational decode of the incoming opcode, highest priority first.
    always_comb begin
        sys_space = (in_insn[31:23] == 9'd0);
        br_space  = (in_insn[31:27] == 5'b01001);
        dec_class = ClsIll;
        if (sys_space && in_insn[7:0] == 8'h0D) begin
            dec_class = ClsMts;
        end else if (sys_space && in_insn[7:0] == 8'h0C) begin
            dec_class = ClsMfs;
        end else if (sys_space && in_insn[7:2] == 6'd0 && in_insn[0]) begin
            dec_class = ClsNop;
        end else if (br_space && in_insn[26:23] == 4'b0000) begin
            dec_class = ClsRet;
        end else if (br_space && in_insn[26:23] == 4'b0010 && in_insn[20:18] == 3'b000) begin
            dec_class = ClsJsrr;
        end
    end

    // A full FIFO blocks input even when the head is popped in the same cycle.
    assign in_ready  = !rst && (state_q == StRun) && (count_q != CNT_W'(DEPTH)) && !redirect;
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign busy      = (state_q != StRun) || (count_q != '0);

    assign head = mem_q[rd_ptr_q];
    assign {out_pc, out_class, out_rd, out_sysreg} = head;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CNT_W'(1);
        end
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (accept) begin
                    if (SERIALIZE_MTS && dec_class == ClsMts) begin
                        state_d = StWaitWr;
                    end else if (dec_class == ClsRet || dec_class == ClsJsrr) begin
                        state_d = StWaitRedir;
                    end
                end
            end
            StWaitWr: begin
                if (sysreg_wr_done) begin
                    state_d = StRun;
                end
            end
            StWaitRedir: state_d = StWaitRedir;
            default:     state_d = StRun;
        endcase
        // Redirect overrides every other event, whatever the current state.
        if (redirect) begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {in_pc, dec_class, in_insn[22:18], in_insn[17:8]};
        end
    end

endmodule

// File: doc/insn_decode_stage.md
INSN_DECODE_STAGE -- requirements
Module: insn_decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of instruction address carried with each instruction.
REQ-002 SHALL have parameter DEPTH, default 4, number of decoded-op FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter SERIALIZE_MTS, default 1; 1 = stall after MTS until write acknowledged, 0 = no stall.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1  fetch-side handshake.
REQ-007 SHALL have port in_insn  input  32  raw instruction opcode.
REQ-008 SHALL have port in_pc  input  PC_W  instruction address.
REQ-009 SHALL have ports out_valid output 1 / out_ready input 1  issue-side handshake.
REQ-010 SHALL have port out_pc  output  PC_W  address of head op.
REQ-011 SHALL have port out_class  output  3  0 NOP, 1 MTS, 2 MFS, 3 RET/RFI, 4 JSRR, 7 ILLEGAL; 5-6 unused.
REQ-012 SHALL have port out_rd  output  5  insn[22:18] of head op.
REQ-013 SHALL have port out_sysreg  output  10  insn[17:8]: [9:7] num, [6:5] privilege level, [4:0] group.
REQ-014 SHALL have port sysreg_wr_done  input  1  one-cycle pulse: outstanding MTS write completed.
REQ-015 SHALL have port redirect  input  1  one-cycle pulse: pipeline flush / control-transfer resolved.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port busy  output  1  high when state != RUN or count != 0.

Function
REQ-018 Decode: NOP = insn[31:23]==0 and insn[7:2]==0 and insn[0]==1.
REQ-019 Decode: MTS = insn[31:23]==0 and insn[7:0]==8'h0D; MFS = insn[31:23]==0 and insn[7:0]==8'h0C.
REQ-020 Decode: RET/RFI = insn[31:27]==5'b01001 and insn[26:23]==4'b0000; JSRR = insn[31:27]==5'b01001, insn[26:23]==4'b0010, insn[20:18]==3'b000.
REQ-021 Priority MTS > MFS > NOP > RET/RFI > JSRR; anything else SHALL decode as ILLEGAL (7).
REQ-022 Decode is combinational on input; class, rd, sysreg, pc written into FIFO on accept (in_valid & in_ready).
REQ-023 FIFO: write/read pointers wrap modulo DEPTH; simultaneous accept and pop leaves count unchanged.
REQ-024 Latency: op accepted in cycle N with empty FIFO SHALL present out_valid=1 in cycle N+1; no same-cycle bypass.
REQ-025 out_valid = (count != 0); head fields stable while out_valid & !out_ready.
REQ-026 in_ready = (state==RUN) & (count < DEPTH) & !redirect; full FIFO blocks input even if popped that cycle.
REQ-027 States: RUN, WAIT_WR, WAIT_REDIR.
REQ-028 RUN -> WAIT_WR on accepting MTS when SERIALIZE_MTS=1; WAIT_WR -> RUN on the cycle after sysreg_wr_done=1.
REQ-029 RUN -> WAIT_REDIR on accepting RET/RFI or JSRR; WAIT_REDIR -> RUN on the cycle after redirect=1.
REQ-030 sysreg_wr_done SHALL be ignored outside WAIT_WR, including the cycle the MTS is accepted.
REQ-031 redirect SHALL, in any state: empty FIFO (count=0 next cycle), force state RUN, drop any input that cycle; redirect wins over all simultaneous events.
REQ-032 Pops continue in WAIT_WR / WAIT_REDIR; ILLEGAL ops enqueue normally without state change.

Reset
REQ-033 On rst=1 at clock edge: state=RUN, pointers=0, count=0, out_valid=0, busy=0; in_ready=1 on the first cycle after rst deasserts.
REQ-034 rst mid-operation SHALL discard all FIFO contents and pending stall without waiting for acknowledgements.
REQ-035 While rst=1, in_ready SHALL be 0.

Verification
REQ-036 Single op: insn=32'h0000_0001 accepted cycle N, out_ready=1 -> cycle N+1 out_valid=1, out_class=0, count=1; N+2 count=0.
REQ-037 MTS serialize: insn=32'h0014_030D (rd=5, sysreg=10'h003) -> out_class=1, out_rd=5, out_sysreg=10'h003, in_ready=0 until cycle after sysreg_wr_done; with SERIALIZE_MTS=0 in_ready stays 1.
REQ-038 Full FIFO: out_ready=0, push DEPTH NOPs -> count=DEPTH, in_ready=0; pop one with in_valid=1 -> no accept that cycle, accept next cycle, pointer wrap preserves order.
REQ-039 Branch fence: insn=32'h4800_0000 -> class 3, state WAIT_REDIR, in_ready=0; redirect pulse with 2 ops queued -> count=0, in_ready=1 next cycle.
REQ-040 Illegal/redirect race: insn=32'hFFFF_FFFF -> class 7 no stall; redirect concurrent with in_valid -> input not enqueued, count=0.
REQ-041 Reset during WAIT_WR with count=3 -> count=0, out_valid=0, busy=0, in_ready=1 after release.
